// File: rtl/demux_16bit_1to4_buf_pkg.sv
// Shared definitions for the 1-to-4 buffered demux: default width, channel count
// and the select encodings, plus the select-to-one-hot decode used by the top.
package demux_16bit_1to4_buf_pkg;

    localparam int DEMUX_WIDTH = 16;
    localparam int NUM_CH      = 4;

    typedef enum logic [1:0] {
        CH0 = 2'd0,
        CH1 = 2'd1,
        CH2 = 2'd2,
        CH3 = 2'd3
    } ch_sel_e;

    function automatic logic [NUM_CH-1:0] sel_decode(input logic [1:0] sel);
        logic [NUM_CH-1:0] onehot;
        onehot = '0;
        case (ch_sel_e'(sel))
            CH0:     onehot = 4'b0001;
            CH1:     onehot = 4'b0010;
            CH2:     onehot = 4'b0100;
            CH3:     onehot = 4'b1000;
            default: onehot = '0;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/demux_16bit_1to4_buf_slot.sv
// Single-entry holding register for one demux channel. Flush beats push,
// push beats pop, so a same-cycle push and pop keeps the slot full.
module demux_16bit_1to4_buf_slot #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (push) begin
            valid_d = 1'b1;
            data_d  = push_data;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/demux_16bit_1to4_buf.sv
// Steers one producer stream into one of four single-entry slots chosen by sel;
// a stalled consumer only blocks pushes aimed at its own slot.
module demux_16bit_1to4_buf
    import demux_16bit_1to4_buf_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        sel,
    input  logic [WIDTH-1:0]  in_data,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [WIDTH-1:0]  out_data_0,
    output logic [WIDTH-1:0]  out_data_1,
    output logic [WIDTH-1:0]  out_data_2,
    output logic [WIDTH-1:0]  out_data_3,
    output logic              busy
);

    logic [NUM_CH-1:0] slot_valid;
    logic [NUM_CH-1:0] push_vec;
    logic [WIDTH-1:0]  slot_data [NUM_CH];

    // A full slot can still accept if its consumer drains it on the same edge.
    assign in_ready = ~flush & (~slot_valid[sel] | out_ready[sel]);
    assign push_vec = (in_valid & in_ready) ? sel_decode(sel) : '0;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
        demux_16bit_1to4_buf_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .push      (push_vec[i]),
            .push_data (in_data),
            .pop       (slot_valid[i] & out_ready[i]),
            .valid     (slot_valid[i]),
            .data      (slot_data[i])
        );
    end

    assign out_valid  = slot_valid;
    assign out_data_0 = slot_data[0];
    assign out_data_1 = slot_data[1];
    assign out_data_2 = slot_data[2];
    assign out_data_3 = slot_data[3];
    assign busy       = |slot_valid;

endmodule

// File: tb/tb_demux_16bit_1to4_buf.sv
// Directed bench for the 1-to-4 buffered demux: a per-channel slot model is
// compared against the DUT every cycle, alongside hand-computed literal checks.
module tb_demux_16bit_1to4_buf;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  sel;
    logic [15:0] in_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [15:0] out_data_0, out_data_1, out_data_2, out_data_3;
    logic        busy;

    int checks = 0;
    int errors = 0;
    bit checkEn = 0;

    bit          mValid [4];
    logic [15:0] mData  [4];

    demux_16bit_1to4_buf #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sel        (sel),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data_0 (out_data_0),
        .out_data_1 (out_data_1),
        .out_data_2 (out_data_2),
        .out_data_3 (out_data_3),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each channel is a one-deep holding slot; flush empties all,
    // a pop empties a full slot, and an accepted push fills the selected one.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                mValid[i] = 1'b0;
                mData[i]  = 16'h0000;
            end
        end else if (flush) begin
            for (int i = 0; i < 4; i++) mValid[i] = 1'b0;
        end else begin
            bit canTake;
            canTake = !mValid[sel] || out_ready[sel];
            for (int i = 0; i < 4; i++)
                if (mValid[i] && out_ready[i]) mValid[i] = 1'b0;
            if (in_valid && canTake) begin
                mValid[sel] = 1'b1;
                mData[sel]  = in_data;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (checkEn && rst_n) begin
            logic [3:0] expValid;
            logic       expRdy;
            for (int i = 0; i < 4; i++) expValid[i] = mValid[i];
            expRdy = !flush && (!mValid[sel] || out_ready[sel]);
            checkOutput("model_out_valid", {12'h0, out_valid}, {12'h0, expValid});
            checkOutput("model_busy", {15'h0, busy}, {15'h0, |expValid});
            checkOutput("model_in_ready", {15'h0, in_ready}, {15'h0, expRdy});
            if (mValid[0]) checkOutput("model_data0", out_data_0, mData[0]);
            if (mValid[1]) checkOutput("model_data1", out_data_1, mData[1]);
            if (mValid[2]) checkOutput("model_data2", out_data_2, mData[2]);
            if (mValid[3]) checkOutput("model_data3", out_data_3, mData[3]);
        end
    end

    task automatic applyStimulus(input logic v, input logic [1:0] s, input logic [15:0] d,
                                 input logic [3:0] ordy, input logic fl);
        @(posedge clk);
        #1;
        in_valid  = v;
        sel       = s;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        sel       = 2'd0;
        in_data   = 16'h0;
        out_ready = 4'h0;

        // Reset held with random inputs
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid  = 1'($urandom);
            sel       = 2'($urandom);
            in_data   = 16'($urandom);
            out_ready = 4'($urandom);
            flush     = 1'($urandom);
            #1;
            checkOutput("rst_out_valid", {12'h0, out_valid}, 16'h0000);
            checkOutput("rst_busy", {15'h0, busy}, 16'h0000);
            checkOutput("rst_data0", out_data_0, 16'h0000);
            checkOutput("rst_data3", out_data_3, 16'h0000);
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        rst_n    = 1'b1;
        #1;
        checkOutput("rst_release_in_ready", {15'h0, in_ready}, 16'h0001);
        checkEn = 1'b1;

        // Basic steer to channel 2
        applyStimulus(1'b1, 2'd2, 16'hA5A5, 4'b0000, 1'b0);
        #1 checkOutput("steer_in_ready", {15'h0, in_ready}, 16'h0001);
        applyStimulus(1'b0, 2'd0, 16'h0000, 4'b0100, 1'b0);
        checkOutput("steer_out_valid", {12'h0, out_valid}, 16'h0004);
        checkOutput("steer_data2", out_data_2, 16'hA5A5);
        checkOutput("steer_busy", {15'h0, busy}, 16'h0001);
        applyStimulus(1'b0, 2'd0, 16'h0000, 4'b0000, 1'b0);
        checkOutput("steer_drained", {12'h0, out_valid}, 16'h0000);

        // Backpressure isolation
        applyStimulus(1'b1, 2'd1, 16'h1111, 4'b0000, 1'b0);
        applyStimulus(1'b1, 2'd1, 16'h2222, 4'b0000, 1'b0);
        #1 checkOutput("bp_in_ready_low", {15'h0, in_ready}, 16'h0000);
        applyStimulus(1'b1, 2'd1, 16'h2222, 4'b0000, 1'b0);
        checkOutput("bp_slot1_held", out_data_1, 16'h1111);
        applyStimulus(1'b1, 2'd3, 16'h3333, 4'b0000, 1'b0);
        #1 checkOutput("bp_other_ready", {15'h0, in_ready}, 16'h0001);
        applyStimulus(1'b0, 2'd0, 16'h0000, 4'b0000, 1'b0);
        checkOutput("bp_out_valid", {12'h0, out_valid}, 16'h000A);
        checkOutput("bp_data3", out_data_3, 16'h3333);
        checkOutput("bp_data1", out_data_1, 16'h1111);
        applyStimulus(1'b0, 2'd0, 16'h0000, 4'b1010, 1'b0);
        applyStimulus(1'b0, 2'd0, 16'h0000, 4'b0000, 1'b0);

        // Streaming on channel 0
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 2'd0, 16'(k), 4'b0001, 1'b0);
            #1 checkOutput("stream_in_ready", {15'h0, in_ready}, 16'h0001);
            if (k > 1) begin
                checkOutput("stream_valid0", {15'h0, out_valid[0]}, 16'h0001);
                checkOutput("stream_data0", out_data_0, 16'(k - 1));
            end
        end
        applyStimulus(1'b0, 2'd0, 16'h0000, 4'b0001, 1'b0);
        checkOutput("stream_last", out_data_0, 16'h0004);
        checkOutput("stream_last_valid", {12'h0, out_valid}, 16'h0001);
        applyStimulus(1'b0, 2'd0, 16'h0000, 4'b0000, 1'b0);
        checkOutput("stream_empty", {12'h0, out_valid}, 16'h0000);

        // Flush priority
        applyStimulus(1'b1, 2'd0, 16'hAAAA, 4'b0000, 1'b0);
        applyStimulus(1'b1, 2'd2, 16'hCCCC, 4'b0000, 1'b0);
        applyStimulus(1'b1, 2'd1, 16'hBEEF, 4'b0000, 1'b1);
        checkOutput("flush_pre_valid", {12'h0, out_valid}, 16'h0005);
        #1 checkOutput("flush_in_ready", {15'h0, in_ready}, 16'h0000);
        applyStimulus(1'b0, 2'd0, 16'h0000, 4'b0000, 1'b0);
        checkOutput("flush_out_valid", {12'h0, out_valid}, 16'h0000);

        // Asynchronous reset mid-stream
        applyStimulus(1'b1, 2'd0, 16'h1234, 4'b0000, 1'b0);
        applyStimulus(1'b1, 2'd3, 16'h4321, 4'b0000, 1'b0);
        applyStimulus(1'b0, 2'd0, 16'h0000, 4'b0000, 1'b0);
        checkOutput("arst_pre_valid", {12'h0, out_valid}, 16'h0009);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_out_valid", {12'h0, out_valid}, 16'h0000);
        checkOutput("arst_busy", {15'h0, busy}, 16'h0000);
        checkOutput("arst_data0", out_data_0, 16'h0000);
        #1 rst_n = 1'b1;

        // Mixed traffic against the model
        for (int k = 0; k < 40; k++)
            applyStimulus(1'($urandom), 2'($urandom), 16'($urandom), 4'($urandom),
                          ($urandom_range(0, 9) == 0));
        applyStimulus(1'b0, 2'd0, 16'h0000, 4'b0000, 1'b0);
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
